// File: rtl/mdu_pkg.sv
// M-extension op codes, FSM encoding and divider constants
// shared by the MDU sequencer, its interface and its bench.
package mdu_pkg;

  localparam logic [2:0] MUL_F3    = 3'b000;
  localparam logic [2:0] MULH_F3   = 3'b001;
  localparam logic [2:0] MULHSU_F3 = 3'b010;
  localparam logic [2:0] MULHU_F3  = 3'b011;
  localparam logic [2:0] DIV_F3    = 3'b100;
  localparam logic [2:0] DIVU_F3   = 3'b101;
  localparam logic [2:0] REM_F3    = 3'b110;
  localparam logic [2:0] REMU_F3   = 3'b111;

  localparam int DIV_STEPS = 32;
  localparam int CNT_W     = 6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

endpackage

// File: rtl/mdu_sequencer_if.sv
// EX-stage <-> MDU operand/result bundle.
// The EX stage is master, the sequencer is slave.
interface mdu_sequencer_if #(
  parameter int XLEN = 32
);

  logic            en_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic [XLEN-1:0] result_o;
  logic            done_o;

  modport master (
    output en_i, op_i, rs1_i, rs2_i,
    input  result_o, done_o
  );

  modport slave (
    input  en_i, op_i, rs1_i, rs2_i,
    output result_o, done_o
  );

endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division step on unsigned magnitudes:
// shift {rem,quo} left, subtract divisor if it fits.
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);

  logic [XLEN:0] sh;
  logic [XLEN:0] diff;

  // rem < dvs always holds, so diff MSB is a clean borrow flag
  assign sh      = {rem, quo[XLEN-1]};
  assign diff    = sh - {1'b0, dvs};
  assign rem_nxt = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_nxt = {quo[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/mdu_sequencer.sv
// EX-stage multiply/divide sequencer: pipelined multiplier,
// 32-step restoring divider, stall and done generation.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          ex_en_i,
  input  logic          flush_i,
  mdu_sequencer_if.slave bus,
  output logic          mul_stall_o,
  output logic          div_stall_o
);

  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic             res_ld;

  logic [XLEN-1:0] rs1, rs2;
  logic [2:0]      op;
  logic            accept, is_mul;

  assign rs1    = bus.rs1_i;
  assign rs2    = bus.rs2_i;
  assign op     = bus.op_i;
  assign is_mul = ~op[2];
  assign accept = (state_q == S_IDLE) & bus.en_i
                & ex_en_i & ~flush_i;

  // multiplier front end: 33x33 signed product from live operands
  logic                   a_sgn, b_sgn;
  logic signed [2*XLEN-1:0] ma, mb, prod;
  logic [XLEN-1:0]        mul_res, mul_tap;

  assign a_sgn   = (op != MULHU_F3);
  assign b_sgn   = ~op[1];
  assign ma      = {{XLEN{a_sgn & rs1[XLEN-1]}}, rs1};
  assign mb      = {{XLEN{b_sgn & rs2[XLEN-1]}}, rs2};
  assign prod    = ma * mb;
  assign mul_res = (op == MUL_F3) ? prod[XLEN-1:0]
                                  : prod[2*XLEN-1:XLEN];

  if (MUL_LAT == 1) begin : g_lat1
    assign mul_tap = mul_res;
  end else begin : g_pipe
    logic [XLEN-1:0] pipe [MUL_LAT-1];
    // free-running product pipeline; the FSM picks the right slot
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < MUL_LAT-1; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= mul_res;
        for (int i = 1; i < MUL_LAT-1; i++) pipe[i] <= pipe[i-1];
      end
    end
    assign mul_tap = pipe[MUL_LAT-2];
  end

  // divider operand prep and short-circuit cases
  logic            sgn_div, zero_div, ovf, special;
  logic [XLEN-1:0] abs1, abs2, spec_res;

  assign sgn_div  = ~op[0];
  assign abs1     = (sgn_div & rs1[XLEN-1]) ? -rs1 : rs1;
  assign abs2     = (sgn_div & rs2[XLEN-1]) ? -rs2 : rs2;
  assign zero_div = (rs2 == '0);
  assign ovf      = sgn_div & (rs1 == MIN_NEG) & (rs2 == '1);
  assign special  = zero_div | ovf;
  assign spec_res = zero_div ? (op[1] ? rs1 : '1)
                             : (op[1] ? '0 : rs1);

  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [XLEN-1:0] rem_nxt, quo_nxt, div_res;
  logic            negq_q, negr_q, isrem_q;

  mdu_div_step #(.XLEN(XLEN)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .dvs     (dvs_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  assign div_res = isrem_q ? (negr_q ? -rem_nxt : rem_nxt)
                           : (negq_q ? -quo_nxt : quo_nxt);

  // state and counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state, stalls, done and result-load decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mul_stall_o = 1'b0;
    div_stall_o = 1'b0;
    bus.done_o  = 1'b0;
    res_ld      = 1'b0;
    res_d       = div_res;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept && is_mul) begin
          mul_stall_o = 1'b1;
          if (MUL_LAT == 1) begin
            state_d = S_DONE;
            res_ld  = 1'b1;
            res_d   = mul_tap;
          end else begin
            state_d = S_MUL;
          end
        end else if (accept) begin
          div_stall_o = 1'b1;
          if (special) begin
            state_d = S_DONE;
            res_ld  = 1'b1;
            res_d   = spec_res;
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        mul_stall_o = 1'b1;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MUL_LAT-2)) begin
          state_d = S_DONE;
          res_ld  = 1'b1;
          res_d   = mul_tap;
        end
      end
      S_DIV: begin
        div_stall_o = 1'b1;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_STEPS-1)) begin
          state_d = S_DONE;
          res_ld  = 1'b1;
        end
      end
      S_DONE: begin
        bus.done_o = 1'b1;
        if (ex_en_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      mul_stall_o = 1'b0;
      div_stall_o = 1'b0;
      bus.done_o  = 1'b0;
      res_ld      = 1'b0;
    end
  end

  // operand latch, divider iteration and result hold
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      isrem_q <= 1'b0;
    end else begin
      if (res_ld) res_q <= res_d;
      if (accept) begin
        rem_q   <= '0;
        quo_q   <= abs1;
        dvs_q   <= abs2;
        negq_q  <= sgn_div & (rs1[XLEN-1] ^ rs2[XLEN-1]);
        negr_q  <= sgn_div & rs1[XLEN-1];
        isrem_q <= op[1];
      end else if (state_q == S_DIV) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
      end
    end
  end

  assign bus.result_o = res_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed-vector scoreboard bench for mdu_sequencer.
// Driver pushes expectations; a forked monitor pops on done.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ex_en = 1'b1;
  logic flush = 1'b0;
  logic mul_stall, div_stall;

  mdu_sequencer_if bus ();

  mdu_sequencer #(.XLEN(32), .MUL_LAT(2)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .ex_en_i     (ex_en),
    .flush_i     (flush),
    .bus         (bus),
    .mul_stall_o (mul_stall),
    .div_stall_o (div_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          mst;
    int          dst;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic prev_done;
    int   mcnt, dcnt;
    exp_t cur;
    prev_done = 1'b0;
    mcnt = 0;
    dcnt = 0;
    cur  = '{32'h0, 0, 0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_done = 1'b0;
        mcnt = 0;
        dcnt = 0;
        continue;
      end
      if (bus.done_o && !prev_done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'h1, 32'h0);
        end else begin
          cur = sb_q.pop_front();
          chk("result", bus.result_o, cur.res);
          chk("mul_stalls", 32'(mcnt), 32'(cur.mst));
          chk("div_stalls", 32'(dcnt), 32'(cur.dst));
        end
        mcnt = 0;
        dcnt = 0;
      end else if (bus.done_o) begin
        chk("held_result", bus.result_o, cur.res);
      end
      if (mul_stall) mcnt++;
      if (div_stall) dcnt++;
      if (!mul_stall && !div_stall && !bus.done_o) begin
        mcnt = 0;
        dcnt = 0;
      end
      prev_done = bus.done_o;
    end
  endtask

  task automatic run_op(input logic [2:0]  op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp,
                        input int          stalls,
                        input int          hold,
                        input bit          drop);
    bit seen;
    sb_q.push_back('{exp, op[2] ? 0 : stalls,
                     op[2] ? stalls : 0});
    @(posedge clk); #1;
    bus.en_i  = 1'b1;
    bus.op_i  = op;
    bus.rs1_i = a;
    bus.rs2_i = b;
    @(posedge clk); #1;
    if (drop) begin
      bus.en_i  = 1'b0;
      bus.rs1_i = 32'hDEADBEEF;
      bus.rs2_i = 32'h0;
    end
    if (hold > 0) ex_en = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done_o) seen = 1'b1;
    end
    if (!seen) begin
      chk("done_timeout", 32'h0, 32'h1);
      void'(sb_q.pop_back());
      ex_en    = 1'b1;
      bus.en_i = 1'b0;
      return;
    end
    if (hold > 0) begin
      for (int i = 1; i < hold; i++) begin
        @(negedge clk);
        chk("busywait_done", 32'(bus.done_o), 32'h1);
      end
      ex_en    = 1'b1;
      bus.en_i = 1'b0;
      @(negedge clk);
      chk("left_done", 32'(bus.done_o), 32'h0);
    end else begin
      bus.en_i = 1'b0;
    end
  endtask

  initial begin
    bus.en_i  = 1'b0;
    bus.op_i  = 3'b0;
    bus.rs1_i = 32'h0;
    bus.rs2_i = 32'h0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result", bus.result_o, 32'h0);
    chk("rst_done", 32'(bus.done_o), 32'h0);
    chk("rst_mul_stall", 32'(mul_stall), 32'h0);
    chk("rst_div_stall", 32'(div_stall), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(MUL_F3,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2, 0, 0);
    run_op(MULHU_F3,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, 0, 0);
    run_op(MULH_F3,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2, 0, 0);
    run_op(MULHSU_F3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 0, 1);
    run_op(DIV_F3,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 0, 0);
    run_op(REM_F3,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 0, 1);
    run_op(DIV_F3,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, 0, 0);
    run_op(REM_F3,    32'd7,        32'hFFFFFFFE, 32'h00000001, 33, 0, 0);
    run_op(REMU_F3,   32'd100,      32'd7,        32'h00000002, 33, 0, 0);
    run_op(DIVU_F3,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33, 0, 0);
    run_op(DIVU_F3,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33, 0, 0);
    run_op(DIVU_F3,   32'd5,        32'd0,        32'hFFFFFFFF, 1, 0, 0);
    run_op(REMU_F3,   32'd5,        32'd0,        32'h00000005, 1, 0, 0);
    run_op(DIV_F3,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1, 0, 0);
    run_op(REM_F3,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 0, 0);
    run_op(DIV_F3,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, 0);

    // flush in IDLE blocks acceptance
    @(posedge clk); #1;
    bus.en_i  = 1'b1;
    bus.op_i  = MUL_F3;
    bus.rs1_i = 32'd3;
    bus.rs2_i = 32'd3;
    flush     = 1'b1;
    @(negedge clk);
    chk("idle_flush_stall", 32'(mul_stall), 32'h0);
    @(posedge clk); #1;
    bus.en_i = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    chk("idle_flush_noacc", 32'(mul_stall | div_stall), 32'h0);

    // DIVU 100/7 flushed at cycle 10
    @(posedge clk); #1;
    bus.en_i  = 1'b1;
    bus.op_i  = DIVU_F3;
    bus.rs1_i = 32'd100;
    bus.rs2_i = 32'd7;
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_flush_stall", 32'(div_stall), 32'h1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_div_stall", 32'(div_stall), 32'h0);
    chk("flush_done", 32'(bus.done_o), 32'h0);
    bus.en_i = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("post_flush_stall", 32'(div_stall | mul_stall), 32'h0);
    chk("post_flush_done", 32'(bus.done_o), 32'h0);
    repeat (5) @(negedge clk);
    run_op(DIVU_F3, 32'd100, 32'd7, 32'h0000000E, 33, 0, 0);

    // busywait: ex_en low through the op and 3 DONE cycles
    run_op(DIV_F3, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 33, 3, 0);

    // reset mid-op
    @(posedge clk); #1;
    bus.en_i  = 1'b1;
    bus.op_i  = DIVU_F3;
    bus.rs1_i = 32'd9;
    bus.rs2_i = 32'd2;
    @(posedge clk); #1;
    bus.en_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", 32'(div_stall | mul_stall), 32'h0);
    chk("midrst_done", 32'(bus.done_o), 32'h0);
    chk("midrst_result", bus.result_o, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(MUL_F3, 32'h12345678, 32'h10, 32'h23456780, 2, 0, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
